// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the data stage.
// Optional wait/conflict performance counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_be_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_wait_o,
    output logic [31:0]         perf_dm_wait_o,
    output logic [31:0]         perf_conflict_o
`endif
);

    localparam int BE_W  = DATA_W / 8;
    // Keep the counter at least one bit wide so STARVE_LIMIT=0 still elaborates.
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;   // 0 = fetch, 1 = data
    logic [CNT_W-1:0] starve_q, starve_d;

    logic both_req;
    logic fetch_forced;
    logic arb_owner;
    logic cur_owner;
    logic grant;
    logic resp;

    // Arbitration and memory-side request muxing.
    always_comb begin
        both_req     = if_req_i & dm_req_i;
        fetch_forced = (STARVE_LIMIT != 0) && (starve_q == CNT_MAX);
        arb_owner    = dm_req_i & ~(both_req & fetch_forced);
        cur_owner    = (state_q == IDLE) ? arb_owner : owner_q;

        mem_req_o = 1'b0;
        if (state_q == IDLE) begin
            mem_req_o = if_req_i | dm_req_i;
        end else if (state_q == REQ) begin
            mem_req_o = 1'b1;
        end

        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (cur_owner) begin
                mem_we_o    = dm_we_i;
                mem_be_o    = dm_be_i;
                mem_addr_o  = dm_addr_i;
                mem_wdata_o = dm_wdata_i;
            end else begin
                mem_be_o    = {BE_W{1'b1}};
                mem_addr_o  = if_addr_i;
            end
        end

        grant    = mem_req_o & mem_gnt_i;
        if_gnt_o = grant & ~cur_owner;
        dm_gnt_o = grant & cur_owner;
    end

    // Response routing: only the owner of the outstanding transaction sees it.
    always_comb begin
        resp        = (state_q == WAIT) & mem_rvalid_i;
        if_rvalid_o = resp & ~owner_q;
        dm_rvalid_o = resp & owner_q;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;

        case (state_q)
            IDLE: begin
                if (mem_req_o) begin
                    owner_d = arb_owner;
                    state_d = mem_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Count data wins that left fetch waiting; any fetch win clears the streak.
        if (grant) begin
            if (!cur_owner) begin
                starve_d = '0;
            end else if (if_req_i && (starve_q != CNT_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait_q, perf_if_wait_d;
    logic [31:0] perf_dm_wait_q, perf_dm_wait_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;

    always_comb begin
        perf_if_wait_d  = perf_if_wait_q  + ((if_req_i && !if_gnt_o) ? 32'd1 : 32'd0);
        perf_dm_wait_d  = perf_dm_wait_q  + ((dm_req_i && !dm_gnt_o) ? 32'd1 : 32'd0);
        perf_conflict_d = perf_conflict_q + (((state_q == IDLE) && both_req) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_wait_q  <= '0;
            perf_dm_wait_q  <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_if_wait_q  <= perf_if_wait_d;
            perf_dm_wait_q  <= perf_dm_wait_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_if_wait_o  = perf_if_wait_q;
    assign perf_dm_wait_o  = perf_dm_wait_q;
    assign perf_conflict_o = perf_conflict_q;
`endif

endmodule
